bht_update_queue: RTL

Buffers resolved conditional-branch outcomes from the branch unit and presents them one per cycle to the branch history table's update port. The branch unit never stalls, so the queue drops updates when full and counts the drops. It sits between the execute-stage branch unit (upstream) and the frontend BHT (downstream). Flush and debug-mode gating are applied here, so the BHT only ever sees legal, architecturally relevant updates.

---
 rtl/bht_update_queue.sv | 102 ++++++++++
 1 files changed

// File: rtl/bht_update_queue.sv
// Circular queue of resolved branch outcomes feeding the BHT update port; drops (and counts) when full.
// Optional build macro BHT_UPD_COALESCE_EN merges a repeat of the most recently queued PC into that entry.
module bht_update_queue #(
    parameter int DEPTH      = 4,
    parameter int VLEN       = 64,
    parameter int DROP_CNT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic                       resolve_valid_i,
    input  logic [VLEN-1:0]            resolve_pc_i,
    input  logic                       resolve_taken_i,
    output logic                       upd_valid_o,
    output logic [VLEN-1:0]            upd_pc_o,
    output logic                       upd_taken_o,
    input  logic                       upd_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [DROP_CNT_W-1:0]      drop_cnt_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [VLEN-1:0]       pc_mem [DEPTH];
    logic [DEPTH-1:0]      taken_mem;

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    logic                  deq, req, enq, drop, coal, full;
    logic [PTR_W-1:0]      last_ptr;

    always_comb begin
        deq      = (count_q != '0) && upd_ready_i;
        req      = resolve_valid_i && !debug_mode_i && !flush_i;
        full     = (count_q == FULL_CNT);
        last_ptr = tail_q - PTR_W'(1);
`ifdef BHT_UPD_COALESCE_EN
        // A sole entry leaving this cycle can no longer absorb the repeat.
        coal = req && (count_q != '0) && (pc_mem[last_ptr] == resolve_pc_i)
               && !(deq && (count_q == CNT_W'(1)));
`else
        coal = 1'b0;
`endif
        enq  = req && !coal && (!full || deq);
        drop = req && !coal && full && !deq;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        drop_d  = drop_q;

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (deq) head_d = head_q + PTR_W'(1);
            if (enq) tail_d = tail_q + PTR_W'(1);
            if (enq && !deq)      count_d = count_q + CNT_W'(1);
            else if (deq && !enq) count_d = count_q - CNT_W'(1);
        end

        if (drop && (drop_q != '1)) drop_d = drop_q + DROP_CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Entry storage carries no reset; visibility is governed by count_q.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            pc_mem[tail_q]    <= resolve_pc_i;
            taken_mem[tail_q] <= resolve_taken_i;
        end else if (coal) begin
            taken_mem[last_ptr] <= resolve_taken_i;
        end
    end

    assign upd_valid_o = (count_q != '0);
    assign upd_pc_o    = upd_valid_o ? pc_mem[head_q] : '0;
    assign upd_taken_o = upd_valid_o ? taken_mem[head_q] : 1'b0;
    assign count_o     = count_q;
    assign drop_cnt_o  = drop_q;

endmodule
